// File: rtl/reg_operand_fetch.sv
// ---------------------------------------------------------------------------
// reg_operand_fetch
//
// Operand-fetch stage between decode and execute. Drives the register file
// read ports from the offered source specifiers, tracks in-flight
// destinations in a busy scoreboard, stalls on read-after-write hazards and
// hands captured operands to execute through a one-entry output register.
// The writeback bus is snooped to clear busy bits.
//
// Optional feature macro: OPERAND_BYPASS_EN
//   defined   : a busy source that is being written back this cycle is not
//               hazarded; its operand is taken straight from wb_data.
//   undefined : any busy source stalls; the instruction issues the cycle
//               after the writeback and reads the register file.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until ready;
// ready may depend combinationally on valid-side inputs.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   in_valid/in_ready              decode handshake
//   in_rs1, in_rs2, in_rd          source / destination specifiers
//   in_rd_wen                      instruction writes in_rd
//   rf_raddr1/2, rf_rdata1/2       combinational register file read ports
//   wb_valid, wb_addr, wb_data     writeback bus (register file write port)
//   out_valid/out_ready            execute handshake
//   out_rs1_data, out_rs2_data     captured operands
//   out_rd, out_rd_wen             forwarded destination info
//   stall_cnt                      number of hazard-stall cycles (wraps)
// ---------------------------------------------------------------------------
module reg_operand_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rs1,
    input  logic [ADDR_WIDTH-1:0] in_rs2,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_wen,
    output logic [ADDR_WIDTH-1:0] rf_raddr1,
    output logic [ADDR_WIDTH-1:0] rf_raddr2,
    input  logic [DATA_WIDTH-1:0] rf_rdata1,
    input  logic [DATA_WIDTH-1:0] rf_rdata2,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_rs1_data,
    output logic [DATA_WIDTH-1:0] out_rs2_data,
    output logic [ADDR_WIDTH-1:0] out_rd,
    output logic                  out_rd_wen,
    output logic [31:0]           stall_cnt
);

    localparam int NREGS = 1 << ADDR_WIDTH;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Current state is kept in a plainly named register so checkers can
    // bind to reg_operand_fetch.state directly.
    state_t state;
    state_t state_next;

    logic [NREGS-1:0]      busy;
    logic [NREGS-1:0]      busy_next;

    logic                  drain;
    logic                  accept;
    logic                  hazard;
    logic                  byp1;
    logic                  byp2;
    logic                  hz1;
    logic                  hz2;
    logic [DATA_WIDTH-1:0] opnd1;
    logic [DATA_WIDTH-1:0] opnd2;

    // ------------------------------------------------------------------
    // Read ports follow the offered specifiers directly.
    // ------------------------------------------------------------------
    assign rf_raddr1 = in_rs1;
    assign rf_raddr2 = in_rs2;

    // ------------------------------------------------------------------
    // Bypass detection and operand selection
    // ------------------------------------------------------------------
`ifdef OPERAND_BYPASS_EN
    // A matching writeback carries the newest value of the register, which
    // the register file only holds after this edge.
    assign byp1 = wb_valid && (wb_addr == in_rs1) && (in_rs1 != '0);
    assign byp2 = wb_valid && (wb_addr == in_rs2) && (in_rs2 != '0);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
    // Writeback data only matters for the bypass path.
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
`endif

    always_comb begin
        opnd1 = rf_rdata1;
        opnd2 = rf_rdata2;
        if (in_rs1 == '0) begin
            opnd1 = '0;
        end else if (byp1) begin
            opnd1 = wb_data;
        end
        if (in_rs2 == '0) begin
            opnd2 = '0;
        end else if (byp2) begin
            opnd2 = wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Hazard and handshake
    // ------------------------------------------------------------------
    assign hz1    = (in_rs1 != '0) && busy[in_rs1] && !byp1;
    assign hz2    = (in_rs2 != '0) && busy[in_rs2] && !byp2;
    assign hazard = hz1 | hz2;
    assign in_ready = drain & !hazard;
    assign accept   = in_valid & in_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (out_ready && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // FSM: outputs
    always_comb begin
        out_valid = (state == FULL);
        drain     = (state == EMPTY) | out_ready;
    end

    // ------------------------------------------------------------------
    // Scoreboard: clear on writeback first, then set on accept, so a
    // same-cycle set and clear of one register leaves it busy (the newly
    // accepted producer is still outstanding). Entry 0 never goes busy.
    // ------------------------------------------------------------------
    always_comb begin
        busy_next = busy;
        if (wb_valid) begin
            busy_next[wb_addr] = 1'b0;
        end
        if (accept && in_rd_wen) begin
            busy_next[in_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // ------------------------------------------------------------------
    // Output register: loads only on accept, otherwise holds so that a
    // stalled execute sees stable operands.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_rd       <= '0;
            out_rd_wen   <= 1'b0;
        end else if (accept) begin
            out_rs1_data <= opnd1;
            out_rs2_data <= opnd2;
            out_rd       <= in_rd;
            out_rd_wen   <= in_rd_wen;
        end
    end

    // Counts cycles where decode offers and the output could drain, but a
    // hazard blocks the accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (in_valid && drain && hazard) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: doc/reg_operand_fetch.md
# reg_operand_fetch

Operand-fetch stage between instruction decode and execute. Accepts decoded register specifiers over a valid/ready handshake and drives the register file's two combinational read ports. It tracks in-flight destination registers in a 32-entry busy scoreboard and stalls on read-after-write hazards. It presents the captured operands to execute through a one-entry pipeline register. The block also snoops the writeback bus that drives the register file write port, to clear busy bits and optionally bypass data.

## Interface
- `DATA_WIDTH`, 32, operand width
- `ADDR_WIDTH`, 5, register specifier width (32 registers, x0 hard zero)

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  decode offers an instruction
- `in_ready`  out  1  stage accepts this cycle
- `in_rs1`, `in_rs2`  in  ADDR_WIDTH  source specifiers
- `in_rd`  in  ADDR_WIDTH  destination specifier
- `in_rd_wen`  in  1  instruction writes `in_rd`
- `rf_raddr1`, `rf_raddr2`  out  ADDR_WIDTH  register file read addresses; combinational copy of `in_rs1`/`in_rs2`
- `rf_rdata1`, `rf_rdata2`  in  DATA_WIDTH  register file read data, combinational, same cycle
- `wb_valid`  in  1  writeback commits this cycle (same signal that drives register file `wen`)
- `wb_addr`  in  ADDR_WIDTH  writeback destination
- `wb_data`  in  DATA_WIDTH  writeback value
- `out_valid`  out  1  operands valid to execute
- `out_ready`  in  1  execute accepts
- `out_rs1_data`, `out_rs2_data`  out  DATA_WIDTH  captured operands
- `out_rd`  out  ADDR_WIDTH; `out_rd_wen`  out  1  forwarded destination info
- `stall_cnt`  out  32  count of hazard-stall cycles

## Operation
- Scoreboard `busy[31:0]`; `busy[0]` is constant 0.
- Hazard on source s, when `s != 0 && busy[s]`, unless the bypass condition holds (see Configuration).
- `hazard = hz(in_rs1) | hz(in_rs2)`. `drain = !out_valid | out_ready`. `in_ready = drain & !hazard`.
- Accept (`in_valid & in_ready`):
  - capture operands into the output register; `out_valid <= 1`;
  - if `in_rd_wen && in_rd != 0`, set `busy[in_rd]`.
- Output consumed without a new accept: `out_valid <= 0`. While `out_valid & !out_ready`, every `out_*` holds stable.
- Source specifier 0 always yields operand 0, regardless of `rf_rdata`.
- Writeback with `wb_valid && wb_addr != 0` clears `busy[wb_addr]`. A writeback to a non-busy register has no scoreboard effect.
- Same-cycle set and clear of the same register: set wins, because the new producer is outstanding.
- `stall_cnt` increments by 1 each cycle with `in_valid & drain & hazard`; it wraps at 2^32.
- FSM: EMPTY (`out_valid=0`) and FULL (`out_valid=1`).
  - EMPTY→FULL on accept.
  - FULL→EMPTY on `out_ready` without accept.
  - FULL→FULL on `!out_ready`, or on `out_ready` with accept.

## Timing
- Reset values: `out_valid=0`, `out_rs*_data=0`, `out_rd=0`, `out_rd_wen=0`, `busy=0`, `stall_cnt=0`. Reset asserted mid-operation discards the held instruction and all busy bits immediately.
- Latency: accept at edge N gives `out_valid=1` in cycle N+1. Full throughput: 1 instruction/cycle with no hazard and `out_ready=1`.
- `in_ready` and `rf_raddr*` are combinational from inputs and state. `out_*` are registered only.
- A busy bit cleared at edge N affects hazard in cycle N+1. The register file write happens at the same edge, so the non-bypass read in N+1 sees the new value.

## Configuration
- `OPERAND_BYPASS_EN` defined:
  - a source with `busy[s]` is not hazarded when `wb_valid && wb_addr == s` in the same cycle;
  - the operand is taken from `wb_data`. Zero-cycle RAW recovery.
- Undefined:
  - no bypass; any busy source stalls;
  - the instruction issues the cycle after the writeback, reading the register file. One extra stall cycle per such hazard.

## Test plan
- Reset, then offer rs1=3, rs2=4 with `rf_rdata`=0x11/0x22 and `out_ready=1` → one cycle later `out_valid=1`, data 0x11/0x22, `stall_cnt=0`.
- Issue rd=5 (wen=1), then offer rs1=5 → `in_ready=0` and `stall_cnt` counts each cycle. Assert `wb_valid`, addr 5, data 0xABCD:
  - with bypass, accept that cycle with `out_rs1_data=0xABCD`;
  - without bypass, accept the next cycle with the register file value.
- Hold `out_ready=0` for 3 cycles with `out_valid=1` → outputs unchanged and `in_ready=0`. Release → next instruction is accepted the same cycle.
- rs1=0 while `rf_rdata1=0xFFFFFFFF` → `out_rs1_data=0`. Issue rd=0 with wen=1 → no stall on later rs=0.
- Same cycle: accept rd=7 and `wb_valid` addr 7 → `busy[7]` remains set, so a following rs1=7 stalls.
- Assert `rst` while FULL with `busy[9]` set → `out_valid=0` asynchronously. After release, rs1=9 is accepted without stall.
